ddrio_rd_align_ctrl: RTL and testbench
======================================

DDRIO_RD_ALIGN_CTRL -- requirements
Module: ddrio_rd_align_ctrl

Interface
REQ-001 Parameter PATTERN, default 8'h5C: training word expected on the deserialized read bus {q8..q1}.
REQ-002 Parameter RST_CYCLES, default 16: number of cycles io_rst is held high per training run, legal range 1..255.
REQ-003 Parameter SETTLE_CYCLES, default 8: wait time after reset release or after an align pulse, legal range 1..255.
REQ-004 Parameter MATCH_COUNT, default 4: number of consecutive matching words required for lock, legal range 1..15.
REQ-005 Parameter MAX_SLIPS, default 8: align pulses allowed before FAIL, legal range 1..15.
REQ-006 Clock: gsclk_il, input, 1 bit, the ddrio input-side system clock; the block has one clock only.
REQ-007 Reset: rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-008 Port start, input, 1 bit: level-sampled request to begin a training run.
REQ-009 Port q, input, 8 bits: {q8,q7,q6,q5,q4,q3,q2,q1} from ddrio.
REQ-010 Port io_rst, output, 1 bit: drives the ddrio rst input; active high.
REQ-011 Port align_0_il, output, 1 bit: single-cycle word-align (bitslip) request to ddrio.
REQ-012 Port busy, output, 1 bit: a training run is in progress.
REQ-013 Port done, output, 1 bit: lock achieved; held high until the next start or reset.
REQ-014 Port fail, output, 1 bit: slip budget exhausted; held high until the next start or reset.
REQ-015 Port slip_cnt, output, 4 bits: number of align pulses issued in the current or last run.

Function
REQ-016 The FSM SHALL have the states IDLE, IO_RST, SETTLE, CHECK, SLIP, DONE and FAIL, and all outputs SHALL be registered.
REQ-017 IDLE: io_rst=1, busy=0; start=1 SHALL move the FSM to IO_RST and SHALL clear done, fail and slip_cnt on the same edge.
REQ-018 IO_RST: io_rst=1 and busy=1 for exactly RST_CYCLES cycles, then the FSM SHALL go to SETTLE.
REQ-019 SETTLE: io_rst=0 and busy=1 for exactly SETTLE_CYCLES cycles, then the FSM SHALL go to CHECK with match_cnt=0.
REQ-020 CHECK: q==PATTERN SHALL increment match_cnt; on reaching MATCH_COUNT consecutive matches the FSM SHALL go to DONE.
REQ-021 CHECK mismatch: match_cnt SHALL clear; if slip_cnt==MAX_SLIPS the FSM SHALL go to FAIL, otherwise it SHALL go to SLIP.
REQ-022 SLIP: align_0_il=1 for exactly one cycle and slip_cnt SHALL increment; next state SETTLE.
REQ-023 align_0_il SHALL be 0 in every state other than SLIP, and it SHALL never be high on two consecutive cycles.
REQ-024 DONE: done=1, busy=0, io_rst=0; start=1 SHALL restart at IO_RST with done cleared and slip_cnt=0.
REQ-025 FAIL: fail=1, busy=0, io_rst=0; start=1 SHALL restart exactly as from DONE.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 done and fail SHALL never be high simultaneously.
REQ-028 slip_cnt SHALL saturate at MAX_SLIPS and SHALL never wrap.
REQ-029 Counters SHALL be sized for the maximum parameter value; the RST_CYCLES and SETTLE_CYCLES counters SHALL be 8 bits wide.
REQ-030 Timing from the edge E0 on which start is sampled, with no slips: io_rst=1 on E0..E(RST_CYCLES-1), CHECK is entered at E(RST_CYCLES+SETTLE_CYCLES), and done rises MATCH_COUNT cycles later.

Reset
REQ-031 While rst_n=0 at a clock edge: state=IDLE, io_rst=1, align_0_il=0, busy=0, done=0, fail=0, slip_cnt=0, all internal counters=0.
REQ-032 Reset SHALL override start and any in-progress run, including mid-SLIP; align_0_il SHALL be 0 on the first edge after reset is sampled.

Verification
REQ-033 Defaults, q held at 8'h5C, start pulsed at E0 -> io_rst high E0..E15, CHECK at E24, done=1 at E28, slip_cnt=0, align_0_il never high.
REQ-034 Behavioural ddrio model whose q rotates by one bit per align pulse, starting 3 slips from PATTERN -> exactly 3 single-cycle align pulses, each separated by at least 9 cycles, then done=1 and slip_cnt=3.
REQ-035 q never equal to 8'h5C -> 8 align pulses are issued, then fail=1, done=0, busy=0, slip_cnt=8.
REQ-036 q matches for 3 cycles, mismatches once, then matches continuously -> one SLIP occurs and match_cnt restarts, so done requires 4 fresh consecutive matches.
REQ-037 rst_n driven low for 1 cycle during SLIP, and start held high through the run -> outputs return to reset values, align_0_il=0 the next cycle, and start is ignored until busy=0.
REQ-038 start held high through DONE -> a new run begins immediately, done clears, and io_rst reasserts for 16 cycles.

Source files
------------

// File: rtl/ddrio_rd_align_ctrl.sv
// ddrio_rd_align_ctrl: read-path word-alignment trainer for a ddrio deserializer.
// Resets the ddrio, lets it settle and checks the deserialized word against
// PATTERN. Each mismatch issues one bitslip pulse, up to MAX_SLIPS pulses.
// Ports:
//   gsclk_il   - input-side system clock (only clock)
//   rst_n      - synchronous active-low reset
//   start      - level-sampled request to begin a training run (ignored while busy)
//   q          - {q8..q1} deserialized read word from ddrio
//   io_rst     - ddrio reset, active high
//   align_0_il - single-cycle word-align (bitslip) request
//   busy       - training run in progress
//   done       - lock achieved, held until next start or reset
//   fail       - slip budget exhausted, held until next start or reset
//   slip_cnt   - align pulses issued in the current or last run
module ddrio_rd_align_ctrl #(
    parameter logic [7:0] PATTERN       = 8'h5C,
    parameter int         RST_CYCLES    = 16,
    parameter int         SETTLE_CYCLES = 8,
    parameter int         MATCH_COUNT   = 4,
    parameter int         MAX_SLIPS     = 8
) (
    input  logic       gsclk_il,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] q,
    output logic       io_rst,
    output logic       align_0_il,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] slip_cnt
);
    typedef enum logic [2:0] {IDLE, IO_RST, SETTLE, CHECK, SLIP, DONE, FAIL} state_t;
    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [3:0] match_cnt, match_n, slip_n;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        match_n = match_cnt;
        slip_n  = slip_cnt;
        case (state)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    state_n = IO_RST;
                    cnt_n   = '0;
                    match_n = '0;
                    slip_n  = '0;
                end
            end
            IO_RST: begin
                state_n = (cnt == 8'(RST_CYCLES - 1)) ? SETTLE : IO_RST;
                cnt_n   = (cnt == 8'(RST_CYCLES - 1)) ? '0 : cnt + 8'd1;
            end
            SETTLE: begin
                state_n = (cnt == 8'(SETTLE_CYCLES - 1)) ? CHECK : SETTLE;
                cnt_n   = (cnt == 8'(SETTLE_CYCLES - 1)) ? '0 : cnt + 8'd1;
                match_n = '0;
            end
            CHECK: begin
                if (q == PATTERN) begin
                    match_n = match_cnt + 4'd1;
                    state_n = (match_cnt == 4'(MATCH_COUNT - 1)) ? DONE : CHECK;
                end else begin
                    match_n = '0;
                    // slip_cnt only increments below MAX_SLIPS, so it saturates there
                    state_n = (slip_cnt == 4'(MAX_SLIPS)) ? FAIL : SLIP;
                    slip_n  = (slip_cnt == 4'(MAX_SLIPS)) ? slip_cnt : slip_cnt + 4'd1;
                end
            end
            SLIP: begin
                state_n = SETTLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they align with the state register.
    always_ff @(posedge gsclk_il) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            match_cnt  <= '0;
            slip_cnt   <= '0;
            io_rst     <= 1'b1;
            align_0_il <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            match_cnt  <= match_n;
            slip_cnt   <= slip_n;
            io_rst     <= (state_n == IDLE) || (state_n == IO_RST);
            align_0_il <= state_n == SLIP;
            busy       <= (state_n == IO_RST) || (state_n == SETTLE) || (state_n == CHECK) || (state_n == SLIP);
            done       <= state_n == DONE;
            fail       <= state_n == FAIL;
        end
    end
endmodule

// File: tb/tb_ddrio_rd_align_ctrl.sv
// tb_ddrio_rd_align_ctrl: scoreboard bench for the ddrio read-align trainer.
`timescale 1ns/1ps
module tb_ddrio_rd_align_ctrl;
    localparam logic [7:0] PAT = 8'h5C;
    localparam int R = 16, S = 8, M = 4, MX = 8;
    localparam int K_AL = 0, K_RISE = 1, K_FALL = 2, K_DONE = 3, K_FAIL = 4;

    typedef struct {int kind; int at; int slips; logic [3:0] flg;} ev_t;

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic [7:0] q;
    logic       io_rst, align_0_il, busy, done, fail;
    logic [3:0] slip_cnt;

    int         cyc = 0;
    logic [2:0] nal = 3'd0;
    logic [2:0] rot_off = 3'd0;
    logic [1:0] mode = 2'd0;
    int         glitch_edge = -10;
    int         deadline = -1;
    int         rst_lo = 1, rst_hi = 3;
    int         n_tot = 0, n_bad = 0;
    ev_t        sb[$];

    ddrio_rd_align_ctrl dut (
        .gsclk_il(clk), .rst_n(rst_n), .start(start), .q(q),
        .io_rst(io_rst), .align_0_il(align_0_il), .busy(busy),
        .done(done), .fail(fail), .slip_cnt(slip_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // ddrio model: each align pulse rotates the deserialized word by one bit
    always @(posedge clk) if (align_0_il === 1'b1) nal <= nal + 3'd1;

    function automatic logic [7:0] rotl(logic [7:0] v, logic [2:0] n);
        logic [7:0] r = v;
        for (int i = 0; i < int'(n); i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    assign q = (mode == 2'd1) ? 8'h00 :
               (mode == 2'd2) ? ((cyc == glitch_edge - 1) ? ~PAT : PAT) :
               rotl(PAT, nal + rot_off);

    task automatic push(int kind, int at, int slips, logic [3:0] flg);
        ev_t e;
        e.kind = kind; e.at = at; e.slips = slips; e.flg = flg;
        sb.push_back(e);
    endtask

    task automatic wait_until(int t);
        while (cyc < t) @(negedge clk);
    endtask

    // flags are {done, fail, busy, io_rst}
    task automatic begin_run(bit restart, output int e0);
        start = 1'b1;
        e0 = cyc + 1;
        if (restart) push(K_RISE, e0, 0, 4'b0011);
        push(K_FALL, e0 + R, 0, 4'b0010);
    endtask

    task automatic run_rot(int k, bit restart);
        int e0;
        mode = 2'd0;
        rot_off = 3'(32 - int'(nal) - k);
        begin_run(restart, e0);
        for (int j = 1; j <= k; j++) push(K_AL, e0 + R + S + 1 + (j - 1) * (S + 2), j, 4'b0010);
        push(K_DONE, e0 + R + S + M + k * (S + 2), k, 4'b1000);
        deadline = e0 + R + S + M + k * (S + 2) + 5;
        @(negedge clk);
        start = 1'b0;
        wait_until(deadline + 1);
    endtask

    initial begin : monitor
        bit p_al = 1'b0, p_io = 1'b1, p_done = 1'b0, p_fail = 1'b0;
        int obs;
        ev_t e;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                n_tot++;
                if (done === 1'b1 && fail === 1'b1) begin
                    n_bad++;
                    $display("FAIL excl edge=%0d done=%b fail=%b want not both high", cyc, done, fail);
                end
                n_tot++;
                if (align_0_il === 1'b1 && p_al) begin
                    n_bad++;
                    $display("FAIL align_twice edge=%0d align high two cycles, want single pulse", cyc);
                end
                if (cyc >= rst_lo && cyc <= rst_hi) begin
                    n_tot++;
                    if ({io_rst, align_0_il, busy, done, fail, slip_cnt} !== 9'b1_0000_0000) begin
                        n_bad++;
                        $display("FAIL reset_vals edge=%0d got io_rst/align/busy/done/fail/slip=%b want 100000000",
                                 cyc, {io_rst, align_0_il, busy, done, fail, slip_cnt});
                    end
                end
                obs = (align_0_il === 1'b1) ? K_AL :
                      (done === 1'b1 && !p_done) ? K_DONE :
                      (fail === 1'b1 && !p_fail) ? K_FAIL :
                      (io_rst !== p_io) ? (io_rst === 1'b1 ? K_RISE : K_FALL) : -1;
                if (obs >= 0) begin
                    n_tot++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_event edge=%0d kind=%0d slip=%0d, want no event", cyc, obs, slip_cnt);
                    end else begin
                        e = sb.pop_front();
                        if (e.kind != obs || e.at != cyc || e.slips != int'(slip_cnt) ||
                            e.flg !== {done, fail, busy, io_rst}) begin
                            n_bad++;
                            $display("FAIL event got kind=%0d edge=%0d slip=%0d flags=%b want kind=%0d edge=%0d slip=%0d flags=%b",
                                     obs, cyc, slip_cnt, {done, fail, busy, io_rst}, e.kind, e.at, e.slips, e.flg);
                        end
                    end
                end
                if (cyc == deadline) begin
                    n_tot++;
                    if (sb.size() != 0) begin
                        n_bad++;
                        $display("FAIL missing_events edge=%0d pending=%0d want 0 (next kind=%0d edge=%0d)",
                                 cyc, sb.size(), sb[0].kind, sb[0].at);
                        sb.delete();
                    end
                end
                p_al   = (align_0_il === 1'b1);
                p_io   = (io_rst === 1'b1);
                p_done = (done === 1'b1);
                p_fail = (fail === 1'b1);
            end
        end
    end

    initial begin : stimulus
        int e0, e1;
        rst_n = 1'b0;
        start = 1'b1;
        wait_until(3);
        rst_n = 1'b1;
        start = 1'b0;
        wait_until(5);
        run_rot(0, 1'b0);
        run_rot(3, 1'b1);
        for (int i = 0; i < 3; i++) run_rot($urandom_range(0, 7), 1'b1);
        mode = 2'd2;
        begin_run(1'b1, e0);
        glitch_edge = e0 + 28;
        push(K_AL, e0 + 28, 1, 4'b0010);
        push(K_DONE, e0 + 28 + 1 + S + M, 1, 4'b1000);
        deadline = e0 + 28 + 1 + S + M + 5;
        @(negedge clk);
        start = 1'b0;
        wait_until(deadline + 1);
        mode = 2'd1;
        begin_run(1'b1, e0);
        for (int j = 1; j <= MX; j++) push(K_AL, e0 + R + S + 1 + (j - 1) * (S + 2), j, 4'b0010);
        push(K_FAIL, e0 + R + S + 1 + MX * (S + 2), MX, 4'b0100);
        deadline = e0 + R + S + 1 + MX * (S + 2) + 5;
        @(negedge clk);
        start = 1'b0;
        wait_until(deadline + 1);
        mode = 2'd1;
        begin_run(1'b1, e0);
        push(K_AL, e0 + R + S + 1, 1, 4'b0010);
        deadline = e0 + 90;
        wait_until(e0 + R + S + 1);
        rst_n = 1'b0;
        rst_lo = e0 + R + S + 2;
        rst_hi = rst_lo;
        push(K_RISE, rst_lo, 0, 4'b0001);
        wait_until(rst_lo);
        rst_n = 1'b1;
        mode = 2'd0;
        rot_off = 3'(32 - int'(nal));
        e1 = rst_lo + 1;
        push(K_FALL, e1 + R, 0, 4'b0010);
        push(K_DONE, e1 + R + S + M, 0, 4'b1000);
        push(K_RISE, e1 + R + S + M + 1, 0, 4'b0011);
        push(K_FALL, e1 + R + S + M + 1 + R, 0, 4'b0010);
        push(K_DONE, e1 + 2 * (R + S + M) + 1, 0, 4'b1000);
        wait_until(e1 + R + S + M + 1);
        start = 1'b0;
        wait_until(deadline + 2);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog edge=%0d bench did not finish, want summary", cyc);
        $fatal(1);
    end
endmodule
